// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared widths and mux-select encodings for the hazard controller
package cpu_defs;

  localparam int REG_W = 5;
  localparam int T_W   = 2;

  // D-stage operand mux: register file, or forwarded from E/M/W
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_E  = 2'b01,
    FWD_M  = 2'b10,
    FWD_W  = 2'b11
  } fwd_d_t;

  // E-stage operand mux: ID/EX register, or forwarded from M/W
  typedef enum logic [1:0] {
    FWDE_REG = 2'b00,
    FWDE_M   = 2'b01,
    FWDE_W   = 2'b10
  } fwd_e_t;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

endpackage

// File: rtl/hazard_stage_pipe.sv
// rtl/hazard_stage_pipe.sv - E/M/W producer records with bubble insertion and saturating Tnew
module hazard_stage_pipe #(
  parameter int REG_W = cpu_defs::REG_W,
  parameter int T_W   = cpu_defs::T_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [REG_W-1:0] d_a3,
  input  logic [T_W-1:0]   d_tnew,
  output logic [REG_W-1:0] e_a3,
  output logic [T_W-1:0]   e_tnew,
  output logic [REG_W-1:0] e_rs,
  output logic [REG_W-1:0] e_rt,
  output logic [REG_W-1:0] m_a3,
  output logic [T_W-1:0]   m_tnew,
  output logic [REG_W-1:0] w_a3
);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3   <= '0;
      e_tnew <= '0;
      e_rs   <= '0;
      e_rt   <= '0;
      m_a3   <= '0;
      m_tnew <= '0;
      w_a3   <= '0;
    end else begin
      w_a3   <= m_a3;
      m_a3   <= e_a3;
      // Tnew counts down toward "forwardable now" and parks at zero
      m_tnew <= (e_tnew == '0) ? '0 : e_tnew - 1'b1;
      if (stall) begin
        e_a3   <= '0;
        e_tnew <= '0;
        e_rs   <= '0;
        e_rt   <= '0;
      end else begin
        e_a3   <= d_a3;
        e_tnew <= d_tnew;
        e_rs   <= d_rs;
        e_rt   <= d_rt;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - D-stage stall decision and D/E forwarding-mux selects
module hazard_ctrl #(
  parameter int REG_W = cpu_defs::REG_W,
  parameter int T_W   = cpu_defs::T_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [T_W-1:0]   d_tuse_rs,
  input  logic [T_W-1:0]   d_tuse_rt,
  input  logic [REG_W-1:0] d_a3,
  input  logic [T_W-1:0]   d_tnew,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt
);
  import cpu_defs::*;

  logic [REG_W-1:0] e_a3, e_rs, e_rt, m_a3, w_a3;
  logic [T_W-1:0]   e_tnew, m_tnew;

  hazard_stage_pipe #(.REG_W(REG_W), .T_W(T_W)) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .d_rs   (d_rs),
    .d_rt   (d_rt),
    .d_a3   (d_a3),
    .d_tnew (d_tnew),
    .e_a3   (e_a3),
    .e_tnew (e_tnew),
    .e_rs   (e_rs),
    .e_rt   (e_rt),
    .m_a3   (m_a3),
    .m_tnew (m_tnew),
    .w_a3   (w_a3)
  );

  logic [REG_W-1:0] d_src [2];
  logic [T_W-1:0]   d_tuse [2];
  logic [REG_W-1:0] e_src [2];
  logic [1:0]       fwd_d [2];
  logic [1:0]       fwd_e [2];

  assign d_src[0]  = d_rs;
  assign d_src[1]  = d_rt;
  assign d_tuse[0] = d_tuse_rs;
  assign d_tuse[1] = d_tuse_rt;
  assign e_src[0]  = e_rs;
  assign e_src[1]  = e_rt;

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fwd_d[i] = FWD_RF;
      fwd_e[i] = FWDE_REG;
      if (d_src[i] != '0) begin
        if (d_tuse[i] != T_W'(TUSE_NONE)) begin
          if (d_src[i] == e_a3 && d_tuse[i] < e_tnew) stall = 1'b1;
          if (d_src[i] == m_a3 && d_tuse[i] < m_tnew) stall = 1'b1;
        end
        // Youngest producer decides; a not-yet-ready one yields RF and relies on stall
        if (d_src[i] == e_a3)      fwd_d[i] = (e_tnew == '0) ? FWD_E : FWD_RF;
        else if (d_src[i] == m_a3) fwd_d[i] = (m_tnew == '0) ? FWD_M : FWD_RF;
        else if (d_src[i] == w_a3) fwd_d[i] = FWD_W;
      end
      if (e_src[i] != '0) begin
        if (e_src[i] == m_a3)      fwd_e[i] = (m_tnew == '0) ? FWDE_M : FWDE_REG;
        else if (e_src[i] == w_a3) fwd_e[i] = FWDE_W;
      end
    end
  end

  assign fwd_d_rs = fwd_d[0];
  assign fwd_d_rt = fwd_d[1];
  assign fwd_e_rs = fwd_e[0];
  assign fwd_e_rt = fwd_e[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed pipeline scenarios plus random traffic against an issue-history model
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_a3      (d_a3),
    .d_tnew    (d_tnew),
    .stall     (stall),
    .fwd_d_rs  (fwd_d_rs),
    .fwd_d_rt  (fwd_d_rt),
    .fwd_e_rs  (fwd_e_rs),
    .fwd_e_rt  (fwd_e_rt)
  );

  always #5 clk = ~clk;

  // hist[k] is the instruction issued k+1 cycles ago (k=0 now in E, 1 in M, 2 in W)
  typedef struct {
    logic [4:0] a3;
    int         tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } rec_t;
  rec_t hist [3];

  function automatic int remaining(int k);
    return (hist[k].tnew > k) ? hist[k].tnew - k : 0;
  endfunction

  function automatic logic m_src_stall(logic [4:0] src, int tuse);
    logic s = 1'b0;
    if (src == 0 || tuse == 3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (hist[k].a3 == src && tuse < remaining(k)) s = 1'b1;
    return s;
  endfunction

  function automatic logic m_stall();
    return m_src_stall(d_rs, int'(d_tuse_rs)) || m_src_stall(d_rt, int'(d_tuse_rt));
  endfunction

  function automatic logic [1:0] m_fwd_d(logic [4:0] src);
    if (src == 0) return 2'd0;
    for (int k = 0; k < 3; k++)
      if (hist[k].a3 == src) begin
        if (k == 2) return 2'd3;
        return (remaining(k) == 0) ? 2'(k + 1) : 2'd0;
      end
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_fwd_e(logic [4:0] src);
    if (src == 0) return 2'd0;
    if (hist[1].a3 == src) return (remaining(1) == 0) ? 2'd1 : 2'd0;
    if (hist[2].a3 == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                       input logic [4:0] rt, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic [1:0] tnew);
    d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
    d_a3 = a3; d_tnew = tnew;
    #2;
  endtask

  task automatic tick();
    logic s;
    s = m_stall();
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 3; k++) hist[k] = '{a3: 5'd0, tnew: 0, rs: 5'd0, rt: 5'd0};
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (s) hist[0] = '{a3: 5'd0, tnew: 0, rs: 5'd0, rt: 5'd0};
      else   hist[0] = '{a3: d_a3, tnew: int'(d_tnew), rs: d_rs, rt: d_rt};
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_d(5'($urandom), 2'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), 2'($urandom));
    tick();
    reset = 1'b0;
    set_d(0, 3, 0, 3, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_d(5'($urandom), 2'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), 2'($urandom));
      tick();
      set_d(5'($urandom_range(1, 31)), 2'd0, 5'($urandom_range(1, 31)), 2'd0, 5'd1, 2'd2);
      checks++;
      if (stall !== 1'b0 || fwd_d_rs !== 2'd0 || fwd_d_rt !== 2'd0 || fwd_e_rs !== 2'd0 || fwd_e_rt !== 2'd0) begin
        failures++;
        $display("FAIL reset_outputs: stall=%b fwd=%b/%b/%b/%b required stall=0 fwd=00", stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt);
      end
    end
    reset = 1'b0;
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd9, 2'd0);
    tick();
    set_d(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_record: stall=%b fwd_d_rs=%b required 0/01", stall, fwd_d_rs);
    end
  endtask

  task automatic test_alu_branch();
    do_reset();
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1);
    tick();
    set_d(5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b1 || fwd_d_rs !== 2'b00) begin
      failures++;
      $display("FAIL alu_branch_stall: stall=%b fwd_d_rs=%b required 1/00", stall, fwd_d_rs);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== 2'b10) begin
      failures++;
      $display("FAIL alu_branch_fwd_m: stall=%b fwd_d_rs=%b required 0/10", stall, fwd_d_rs);
    end
  endtask

  task automatic test_load_use_alu();
    do_reset();
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2);
    tick();
    set_d(5'd2, 2'd1, 5'd5, 2'd1, 5'd6, 2'd1);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall: stall=%b required 1", stall);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || fwd_d_rt !== 2'b00) begin
      failures++;
      $display("FAIL load_use_release: stall=%b fwd_d_rt=%b required 0/00", stall, fwd_d_rt);
    end
    tick();
    set_d(0, 3, 0, 3, 0, 0);
    checks++;
    if (fwd_e_rt !== 2'b10 || fwd_e_rs !== 2'b00) begin
      failures++;
      $display("FAIL load_use_fwd_e: fwd_e_rt=%b fwd_e_rs=%b required 10/00", fwd_e_rt, fwd_e_rs);
    end
  endtask

  task automatic test_load_branch();
    do_reset();
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2);
    tick();
    set_d(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL load_branch_stall%0d: stall=%b required 1", c, stall);
      end
      tick();
    end
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== 2'b11) begin
      failures++;
      $display("FAIL load_branch_fwd_w: stall=%b fwd_d_rs=%b required 0/11", stall, fwd_d_rs);
    end
  endtask

  task automatic test_lui_jr();
    do_reset();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd0);
    tick();
    set_d(5'd7, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== 2'b01) begin
      failures++;
      $display("FAIL lui_jr: stall=%b fwd_d_rs=%b required 0/01", stall, fwd_d_rs);
    end
  endtask

  task automatic test_zero_and_priority();
    do_reset();
    set_d(5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd1);
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd4, 2'd0);
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== 2'b00 || fwd_d_rt !== 2'b00) begin
      failures++;
      $display("FAIL reg_zero: stall=%b fwd=%b/%b required 0/00/00", stall, fwd_d_rs, fwd_d_rt);
    end
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd0);
    tick();
    set_d(5'd4, 2'd0, 5'd4, 2'd1, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== 2'b01 || fwd_d_rt !== 2'b01) begin
      failures++;
      $display("FAIL e_wins: stall=%b fwd=%b/%b required 0/01/01", stall, fwd_d_rs, fwd_d_rt);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_d(5'd1, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_d(5'd5, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== 2'b00) begin
      failures++;
      $display("FAIL reset_midstream: stall=%b fwd_d_rs=%b required 0/00", stall, fwd_d_rs);
    end
  endtask

  task automatic test_random();
    logic [1:0] e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_d(5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      if (c > 0) begin
        checks++;
        if (stall !== m_stall()) begin
          failures++;
          $display("FAIL rand_stall cyc%0d: got %b required %b", c, stall, m_stall());
        end
        e = m_fwd_d(d_rs);
        checks++;
        if (fwd_d_rs !== e) begin
          failures++;
          $display("FAIL rand_fwd_d_rs cyc%0d: got %b required %b", c, fwd_d_rs, e);
        end
        e = m_fwd_d(d_rt);
        checks++;
        if (fwd_d_rt !== e) begin
          failures++;
          $display("FAIL rand_fwd_d_rt cyc%0d: got %b required %b", c, fwd_d_rt, e);
        end
        e = m_fwd_e(hist[0].rs);
        checks++;
        if (fwd_e_rs !== e) begin
          failures++;
          $display("FAIL rand_fwd_e_rs cyc%0d: got %b required %b", c, fwd_e_rs, e);
        end
        e = m_fwd_e(hist[0].rt);
        checks++;
        if (fwd_e_rt !== e) begin
          failures++;
          $display("FAIL rand_fwd_e_rt cyc%0d: got %b required %b", c, fwd_e_rt, e);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) hist[k] = '{a3: 5'd0, tnew: 0, rs: 5'd0, rt: 5'd0};
    reset = 1'b1;
    set_d(0, 3, 0, 3, 0, 0);
    test_reset();
    test_alu_branch();
    test_load_use_alu();
    test_load_branch();
    test_lui_jr();
    test_zero_and_priority();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
